uart_frame_rx: RTL and testbench

//  Receive-side deframer for the "&&payload&&" UART string protocol.

---
 rtl/uart_frame_rx.sv | 136 +++++++++++++
 tb/tb_uart_frame_rx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// Deframer for the "&&payload&&" UART string protocol: strips delimiters, collects the
// payload into a flat buffer, and reports completion, overflow or inactivity timeout.
module uart_frame_rx #(
  parameter int unsigned MAX_LEN     = 137,
  parameter int unsigned TIMEOUT_CLK = 5_000_000,
  parameter logic [7:0]  DELIM       = 8'h26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_vld,
  output logic [MAX_LEN*8-1:0] frame_data,
  output logic [7:0]           frame_len,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int unsigned TO_W    = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
  localparam logic [8:0]  LIMIT   = 9'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLK - 1);
  localparam logic [1:0]  ERR_OVF = 2'b01;
  localparam logic [1:0]  ERR_TMO = 2'b10;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    SOF1    = 5'b00010,
    PAYLOAD = 5'b00100,
    EOF1    = 5'b01000,
    DONE    = 5'b10000
  } state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic [TO_W-1:0] tcnt;
  logic            is_delim;
  logic            fits_one;
  logic            fits_two;
  logic            timeout;

  assign is_delim = (rx_data == DELIM);
  // Widened to 9 bits so cnt+1 / cnt+2 cannot wrap before the capacity compare.
  assign fits_one = (({1'b0, cnt} + 9'd1) <= LIMIT);
  assign fits_two = (({1'b0, cnt} + 9'd2) <= LIMIT);
  // A byte arriving on the terminal count wins; DONE never aborts.
  assign timeout  = (state != IDLE) && (state != DONE) && !rx_vld && (tcnt == TO_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      tcnt       <= '0;
      frame_data <= '0;
      frame_len  <= 8'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if ((state == IDLE) || rx_vld) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TO_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (rx_vld && is_delim) begin
            state <= SOF1;
          end
        end
        SOF1: begin
          if (rx_vld) begin
            if (is_delim) begin
              state      <= PAYLOAD;
              frame_data <= '0;
              cnt        <= 8'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        PAYLOAD: begin
          if (rx_vld) begin
            if (is_delim) begin
              state <= EOF1;
            end else if (!fits_one) begin
              state     <= IDLE;
              frame_err <= 1'b1;
              err_code  <= ERR_OVF;
            end else begin
              frame_data[{cnt, 3'b000} +: 8] <= rx_data;
              cnt <= cnt + 8'd1;
            end
          end
        end
        EOF1: begin
          if (rx_vld) begin
            if (is_delim) begin
              state <= DONE;
            end else if (!fits_two) begin
              state     <= IDLE;
              frame_err <= 1'b1;
              err_code  <= ERR_OVF;
            end else begin
              // A lone delimiter inside the payload is data: keep it ahead of this byte.
              frame_data[{cnt, 3'b000} +: 16] <= {rx_data, DELIM};
              cnt   <= cnt + 8'd2;
              state <= PAYLOAD;
            end
          end
        end
        DONE: begin
          frame_len  <= cnt;
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (timeout) begin
        state     <= IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized self-checking bench for uart_frame_rx against a payload-level protocol model.
module tb_uart_frame_rx;

  localparam int unsigned MAX_LEN = 137;
  localparam int unsigned TMO     = 200;
  localparam int unsigned DW      = MAX_LEN * 8;
  localparam logic [7:0]  AMP     = 8'h26;

  logic          sys_clk;
  logic          sys_rst;
  logic [7:0]    rx_data;
  logic          rx_vld;
  logic [DW-1:0] frame_data;
  logic [7:0]    frame_len;
  logic          frame_done;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          busy;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLK(TMO), .DELIM(AMP)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .frame_data (frame_data),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]    done_len_q[$];
  logic [DW-1:0] done_data_q[$];
  logic [1:0]    err_q[$];

  // Pulse monitor: records every completion/abort and checks they never coincide.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (frame_done || frame_err) begin
        n_cmp++;
        if (frame_done && frame_err) begin
          n_bad++;
          $display("FAIL exclusive: done=%b err=%b, required not both high", frame_done, frame_err);
        end
      end
      if (frame_done) begin
        done_len_q.push_back(frame_len);
        done_data_q.push_back(frame_data);
      end
      if (frame_err) err_q.push_back(err_code);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pack(input logic [7:0] q[$]);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < q.size(); i++) v[8*i +: 8] = q[i];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge sys_clk);
    rx_vld  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    repeat (4) @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_q();
    done_len_q.delete();
    done_data_q.delete();
    err_q.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #2;
    n_cmp++;
    if ({frame_done, frame_err, err_code, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 00000", {frame_done, frame_err, err_code, busy});
    end
    n_cmp++;
    if (frame_len !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_len: got %0d, required 0", frame_len);
    end
    n_cmp++;
    if (frame_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got nonzero, required 0");
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_data;
    exp_data = DW'(24'h314241);
    clear_q();
    send_str("&&AB1&");
    send_byte(AMP);
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: done=%b one cycle after closing byte, required 0", frame_done);
    end
    @(posedge sys_clk);
    #1;
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: done=%b two cycles after closing byte, required 1", frame_done);
    end
    n_cmp++;
    if (frame_len !== 8'd3) begin
      n_bad++;
      $display("FAIL basic_len: got %0d, required 3", frame_len);
    end
    n_cmp++;
    if (frame_data !== exp_data) begin
      n_bad++;
      $display("FAIL basic_data: got %h, required %h", frame_data[31:0], exp_data[31:0]);
    end
    settle();
    n_cmp++;
    if (done_len_q.size() != 1 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_count: done=%0d err=%0d, required 1/0", done_len_q.size(), err_q.size());
    end
  endtask

  task automatic test_escape();
    clear_q();
    send_str("&&a&b&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 1) begin
      n_bad++;
      $display("FAIL escape_count: done=%0d, required 1", done_len_q.size());
    end else begin
      n_cmp++;
      if (done_len_q[0] !== 8'd3) begin
        n_bad++;
        $display("FAIL escape_len: got %0d, required 3", done_len_q[0]);
      end
      n_cmp++;
      if (done_data_q[0] !== DW'(24'h622661)) begin
        n_bad++;
        $display("FAIL escape_data: got %h, required 622661", done_data_q[0][31:0]);
      end
    end
  endtask

  task automatic test_max_len();
    logic [7:0] p[$];
    for (int i = 0; i < MAX_LEN; i++) p.push_back(8'h78);
    clear_q();
    send_str("&&");
    foreach (p[i]) send_byte(p[i]);
    send_str("&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 1 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL max_count: done=%0d err=%0d, required 1/0", done_len_q.size(), err_q.size());
    end else begin
      n_cmp++;
      if (done_len_q[0] !== 8'(MAX_LEN) || done_data_q[0] !== pack(p)) begin
        n_bad++;
        $display("FAIL max_frame: len=%0d, required %0d (or data differs)", done_len_q[0], MAX_LEN);
      end
    end
    clear_q();
    send_str("&&");
    for (int i = 0; i < MAX_LEN + 1; i++) send_byte(8'h78);
    settle();
    n_cmp++;
    if (err_q.size() != 1 || done_len_q.size() != 0) begin
      n_bad++;
      $display("FAIL ovf_count: err=%0d done=%0d, required 1/0", err_q.size(), done_len_q.size());
    end else begin
      n_cmp++;
      if (err_q[0] !== 2'b01) begin
        n_bad++;
        $display("FAIL ovf_code: got %b, required 01", err_q[0]);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_q();
    send_str("&&ab");
    n = 0;
    for (int i = 1; i <= int'(TMO) + 5; i++) begin
      @(posedge sys_clk);
      #1;
      if (frame_err === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != int'(TMO)) begin
      n_bad++;
      $display("FAIL tmo_cycles: err after %0d cycles, required %0d", n, TMO);
    end
    n_cmp++;
    if (err_code !== 2'b10 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_state: code=%b busy=%b, required 10/0", err_code, busy);
    end
    send_str("&&z&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 1 || err_q.size() != 1) begin
      n_bad++;
      $display("FAIL tmo_after_count: done=%0d err=%0d, required 1/1", done_len_q.size(), err_q.size());
    end else begin
      n_cmp++;
      if (done_len_q[0] !== 8'd1 || done_data_q[0] !== DW'(8'h7a)) begin
        n_bad++;
        $display("FAIL tmo_after_frame: len=%0d byte=%h, required 1/7a", done_len_q[0], done_data_q[0][7:0]);
      end
    end
  endtask

  task automatic test_resync();
    clear_q();
    send_str("&x&&Q&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 1 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL resync_count: done=%0d err=%0d, required 1/0", done_len_q.size(), err_q.size());
    end else begin
      n_cmp++;
      if (done_len_q[0] !== 8'd1 || done_data_q[0] !== DW'(8'h51)) begin
        n_bad++;
        $display("FAIL resync_frame: len=%0d byte=%h, required 1/51", done_len_q[0], done_data_q[0][7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    logic [7:0] b;
    int n;
    for (int f = 0; f < 25; f++) begin
      p.delete();
      n = (f < 3) ? f : $urandom_range(0, MAX_LEN);
      // Payload rule: any bytes except an adjacent "&&" pair or a trailing '&'.
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 5) == 0) b = AMP;
        if (b == AMP && (i == n - 1 || (i > 0 && p[i-1] == AMP))) b = 8'h41;
        p.push_back(b);
      end
      clear_q();
      for (int k = $urandom_range(0, 3); k > 0; k--) send_byte(8'h30 + 8'($urandom_range(0, 9)));
      send_str("&&");
      foreach (p[i]) begin
        send_byte(p[i]);
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end
      send_str("&&");
      settle();
      n_cmp++;
      if (done_len_q.size() != 1 || err_q.size() != 0) begin
        n_bad++;
        $display("FAIL rand_count[%0d]: done=%0d err=%0d, required 1/0", f, done_len_q.size(), err_q.size());
      end else begin
        n_cmp++;
        if (done_len_q[0] !== 8'(n)) begin
          n_bad++;
          $display("FAIL rand_len[%0d]: got %0d, required %0d", f, done_len_q[0], n);
        end
        n_cmp++;
        if (done_data_q[0] !== pack(p)) begin
          n_bad++;
          $display("FAIL rand_data[%0d]: low word %h, required %h", f, done_data_q[0][63:0], pack(p) & DW'(64'hFFFF_FFFF_FFFF_FFFF));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_str("&&hi&&&&&&&&k&m&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 3 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: done=%0d err=%0d, required 3/0", done_len_q.size(), err_q.size());
    end else begin
      n_cmp++;
      if ({done_len_q[0], done_len_q[1], done_len_q[2]} !== {8'd2, 8'd0, 8'd3}) begin
        n_bad++;
        $display("FAIL b2b_len: got %0d,%0d,%0d, required 2,0,3", done_len_q[0], done_len_q[1], done_len_q[2]);
      end
      n_cmp++;
      if (done_data_q[2] !== DW'(24'h6d266b)) begin
        n_bad++;
        $display("FAIL b2b_data: got %h, required 6d266b", done_data_q[2][31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_str("&&abc");
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if ({frame_done, frame_err, err_code, busy, frame_len} !== 13'd0) begin
      n_bad++;
      $display("FAIL midrst_ctrl: done=%b err=%b code=%b busy=%b len=%0d, required all 0",
               frame_done, frame_err, err_code, busy, frame_len);
    end
    n_cmp++;
    if (frame_data !== '0) begin
      n_bad++;
      $display("FAIL midrst_data: got %h, required 0", frame_data[31:0]);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    clear_q();
    send_str("&&&&");
    settle();
    n_cmp++;
    if (done_len_q.size() != 1 || err_q.size() != 0) begin
      n_bad++;
      $display("FAIL empty_count: done=%0d err=%0d, required 1/0", done_len_q.size(), err_q.size());
    end else begin
      n_cmp++;
      if (done_len_q[0] !== 8'd0) begin
        n_bad++;
        $display("FAIL empty_len: got %0d, required 0", done_len_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_max_len();
    test_timeout();
    test_resync();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
